// File: rtl/axi4_ram_responder_if.sv
// AXI4 bus bundle between the tree core's external-RAM master and the RAM responder.
// Handshake and payload signals only; clock and reset are separate module ports.
interface axi4_ram_responder_if #(
    parameter int RAM_DATA_WIDTH = 128,
    parameter int RAM_ADDR_WIDTH = 16,
    parameter int RAM_STRB_WIDTH = RAM_DATA_WIDTH / 8,
    parameter int RAM_ID_WIDTH   = 8
);
    logic [RAM_ID_WIDTH-1:0]   awid;
    logic [RAM_ADDR_WIDTH-1:0] awaddr;
    logic [7:0]                awlen;
    logic [2:0]                awsize;
    logic [1:0]                awburst;
    logic                      awlock;
    logic [3:0]                awcache;
    logic [2:0]                awprot;
    logic                      awvalid;
    logic                      awready;

    logic [RAM_DATA_WIDTH-1:0] wdata;
    logic [RAM_STRB_WIDTH-1:0] wstrb;
    logic                      wlast;
    logic                      wvalid;
    logic                      wready;

    logic [RAM_ID_WIDTH-1:0]   bid;
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;

    logic [RAM_ID_WIDTH-1:0]   arid;
    logic [RAM_ADDR_WIDTH-1:0] araddr;
    logic [7:0]                arlen;
    logic [2:0]                arsize;
    logic [1:0]                arburst;
    logic                      arlock;
    logic [3:0]                arcache;
    logic [2:0]                arprot;
    logic                      arvalid;
    logic                      arready;

    logic [RAM_ID_WIDTH-1:0]   rid;
    logic [RAM_DATA_WIDTH-1:0] rdata;
    logic [1:0]                rresp;
    logic                      rlast;
    logic                      rvalid;
    logic                      rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi4_ram_responder.sv
// AXI4 slave backed by a word array; independent read/write engines, one burst each in flight.
// Read data 1 cycle after AR, back-to-back beats under rready; W/B and R hold until accepted.
module axi4_ram_responder #(
    parameter int RAM_DATA_WIDTH = 128,
    parameter int RAM_ADDR_WIDTH = 16,
    parameter int RAM_STRB_WIDTH = RAM_DATA_WIDTH / 8,
    parameter int RAM_ID_WIDTH   = 8,
    parameter int RAM_DEPTH_W    = 10
) (
    input logic                 aclk,
    input logic                 areset,
    axi4_ram_responder_if.slave ram_axi
);
    localparam int         OFS_W       = $clog2(RAM_STRB_WIDTH);
    localparam int         DEPTH       = 1 << RAM_DEPTH_W;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    logic [RAM_DATA_WIDTH-1:0] r_mem [DEPTH];

    wstate_t                   r_wstate;
    logic                      r_awready, r_wready, r_bvalid;
    logic [1:0]                r_bresp;
    logic [RAM_ID_WIDTH-1:0]   r_bid;
    logic [RAM_DEPTH_W-1:0]    r_widx;
    logic [8:0]                r_wcnt;
    logic                      r_wfixed, r_wbad, r_werr;

    rstate_t                   r_rstate;
    logic                      r_arready, r_rvalid, r_rlast;
    logic [1:0]                r_rresp;
    logic [RAM_ID_WIDTH-1:0]   r_rid;
    logic [RAM_DATA_WIDTH-1:0] r_rdata;
    logic [RAM_DEPTH_W-1:0]    r_ridx;
    logic [7:0]                r_rcnt;
    logic                      r_rfixed, r_rbad;

    logic [RAM_DEPTH_W-1:0]    w_aw_idx, w_ar_idx;
    logic                      w_aw_hs, w_w_hs, w_w_last, w_wlast_err, w_mem_we, w_ar_hs, w_r_hs;
    logic                      w_unused;

    assign w_aw_idx    = ram_axi.awaddr[RAM_DEPTH_W+OFS_W-1:OFS_W];
    assign w_ar_idx    = ram_axi.araddr[RAM_DEPTH_W+OFS_W-1:OFS_W];
    assign w_aw_hs     = ram_axi.awvalid & r_awready;
    assign w_w_hs      = ram_axi.wvalid & r_wready;
    assign w_w_last    = (r_wcnt == 9'd1);
    assign w_wlast_err = (ram_axi.wlast != w_w_last);
    assign w_mem_we    = w_w_hs & ~r_wbad;
    assign w_ar_hs     = ram_axi.arvalid & r_arready;
    assign w_r_hs      = r_rvalid & ram_axi.rready;

    // Size, lock, cache, prot and the address bits outside the word index carry no meaning here.
    assign w_unused = ^{ram_axi.awaddr, ram_axi.awsize, ram_axi.awlock, ram_axi.awcache, ram_axi.awprot,
                        ram_axi.araddr, ram_axi.arsize, ram_axi.arlock, ram_axi.arcache, ram_axi.arprot};

    assign ram_axi.awready = r_awready;
    assign ram_axi.wready  = r_wready;
    assign ram_axi.bvalid  = r_bvalid;
    assign ram_axi.bresp   = r_bresp;
    assign ram_axi.bid     = r_bid;
    assign ram_axi.arready = r_arready;
    assign ram_axi.rvalid  = r_rvalid;
    assign ram_axi.rlast   = r_rlast;
    assign ram_axi.rresp   = r_rresp;
    assign ram_axi.rid     = r_rid;
    assign ram_axi.rdata   = r_rdata;

    // Array is never reset; wready is cleared by reset so an aborted burst stops writing at once.
    always_ff @(posedge aclk) begin
        if (w_mem_we) begin
            for (int b = 0; b < RAM_STRB_WIDTH; b++) begin
                if (ram_axi.wstrb[b]) begin
                    r_mem[r_widx][b*8 +: 8] <= ram_axi.wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_bid     <= '0;
            r_widx    <= '0;
            r_wcnt    <= '0;
            r_wfixed  <= 1'b0;
            r_wbad    <= 1'b0;
            r_werr    <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    r_awready <= 1'b1;
                    if (w_aw_hs) begin
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_bid     <= ram_axi.awid;
                        r_widx    <= w_aw_idx;
                        r_wcnt    <= {1'b0, ram_axi.awlen} + 9'd1;
                        r_wfixed  <= (ram_axi.awburst == BURST_FIXED);
                        r_wbad    <= ram_axi.awburst[1];
                        r_werr    <= ram_axi.awburst[1];
                        r_wstate  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_w_hs) begin
                        r_wcnt <= r_wcnt - 9'd1;
                        r_widx <= r_wfixed ? r_widx : r_widx + 1'b1;
                        if (w_wlast_err) begin
                            r_werr <= 1'b1;
                        end
                        // Beat count, not wlast, decides where the burst ends.
                        if (w_w_last) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bresp  <= (r_werr | w_wlast_err) ? RESP_SLVERR : RESP_OKAY;
                            r_wstate <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (ram_axi.bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // r_ridx always points at the beat to present after the current one is accepted.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rid     <= '0;
            r_rdata   <= '0;
            r_ridx    <= '0;
            r_rcnt    <= '0;
            r_rfixed  <= 1'b0;
            r_rbad    <= 1'b0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    r_arready <= 1'b1;
                    if (w_ar_hs) begin
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rid     <= ram_axi.arid;
                        r_rbad    <= ram_axi.arburst[1];
                        r_rfixed  <= (ram_axi.arburst == BURST_FIXED);
                        r_rdata   <= ram_axi.arburst[1] ? '0 : r_mem[w_ar_idx];
                        r_rresp   <= ram_axi.arburst[1] ? RESP_SLVERR : RESP_OKAY;
                        r_rlast   <= (ram_axi.arlen == 8'd0);
                        r_rcnt    <= ram_axi.arlen;
                        r_ridx    <= (ram_axi.arburst == BURST_FIXED) ? w_ar_idx : w_ar_idx + 1'b1;
                        r_rstate  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (w_r_hs) begin
                        if (r_rlast) begin
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_arready <= 1'b1;
                            r_rstate  <= R_IDLE;
                        end else begin
                            r_rdata <= r_rbad ? '0 : r_mem[r_ridx];
                            r_rlast <= (r_rcnt == 8'd1);
                            r_rcnt  <= r_rcnt - 8'd1;
                            r_ridx  <= r_rfixed ? r_ridx : r_ridx + 1'b1;
                        end
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_ram_responder.sv
// Directed bench for axi4_ram_responder: a reference word array plus B/R expectation queues.
module tb_axi4_ram_responder;
    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;

    logic aclk   = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    axi4_ram_responder_if #(.RAM_DATA_WIDTH(128), .RAM_ADDR_WIDTH(16), .RAM_ID_WIDTH(8)) ram_axi ();

    axi4_ram_responder #(
        .RAM_DATA_WIDTH(128), .RAM_ADDR_WIDTH(16), .RAM_ID_WIDTH(8), .RAM_DEPTH_W(10)
    ) dut (
        .aclk    (aclk),
        .areset  (areset),
        .ram_axi (ram_axi)
    );

    typedef struct { logic [7:0] id; logic [1:0] resp; } bexp_t;
    typedef struct { logic [127:0] data; logic [1:0] resp; logic last; } rexp_t;

    bexp_t        exp_b[$];
    rexp_t        exp_r[$];
    logic [127:0] model [1024];
    logic [127:0] wbuf  [256];
    int           n_cmp = 0;
    int           n_err = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic aw_send(input logic [7:0] id, input logic [15:0] addr, input int len, input logic [1:0] burst);
        bit got = 0;
        ram_axi.awid = id; ram_axi.awaddr = addr; ram_axi.awlen = 8'(len); ram_axi.awburst = burst;
        ram_axi.awvalid = 1'b1;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge aclk);
            if (ram_axi.awready) got = 1;
        end
        @(posedge aclk); #1;
        ram_axi.awvalid = 1'b0;
        check("aw_handshake", 128'(got), 128'(1));
    endtask

    task automatic ar_send(input logic [7:0] id, input logic [15:0] addr, input int len, input logic [1:0] burst);
        bit got = 0;
        ram_axi.arid = id; ram_axi.araddr = addr; ram_axi.arlen = 8'(len); ram_axi.arburst = burst;
        ram_axi.arvalid = 1'b1;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge aclk);
            if (ram_axi.arready) got = 1;
        end
        @(posedge aclk); #1;
        ram_axi.arvalid = 1'b0;
        check("ar_handshake", 128'(got), 128'(1));
    endtask

    task automatic write_burst(input logic [7:0] id, input logic [15:0] addr, input int len,
                               input logic [1:0] burst, input logic [15:0] strb, input int wlast_beat);
        bit    got;
        bexp_t e;
        int    base = int'(addr[13:4]);
        int    idx;
        aw_send(id, addr, len, burst);
        exp_b.push_back('{id: id, resp: (burst[1] || wlast_beat != len) ? 2'b10 : 2'b00});
        for (int b = 0; b <= len; b++) begin
            idx = (burst == FIXED) ? base : (base + b) % 1024;
            ram_axi.wdata = wbuf[b]; ram_axi.wstrb = strb;
            ram_axi.wlast = (b == wlast_beat); ram_axi.wvalid = 1'b1;
            got = 0;
            for (int c = 0; c < 50 && !got; c++) begin
                @(negedge aclk);
                if (ram_axi.wready) got = 1;
            end
            @(posedge aclk); #1;
            check("w_beat_accept", 128'(got), 128'(1));
            if (!burst[1]) begin
                for (int k = 0; k < 16; k++) begin
                    if (strb[k]) model[idx][k*8 +: 8] = wbuf[b][k*8 +: 8];
                end
            end
        end
        ram_axi.wvalid = 1'b0; ram_axi.wlast = 1'b0;
        ram_axi.bready = 1'b1;
        got = 0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge aclk);
            if (ram_axi.bvalid) begin
                got = 1;
                e = exp_b.pop_front();
                check("b_id", 128'(ram_axi.bid), 128'(e.id));
                check("b_resp", 128'(ram_axi.bresp), 128'(e.resp));
            end
        end
        @(posedge aclk); #1;
        ram_axi.bready = 1'b0;
        check("b_handshake", 128'(got), 128'(1));
    endtask

    task automatic read_burst(input logic [7:0] id, input logic [15:0] addr, input int len,
                              input logic [1:0] burst, input bit stall, input int stop_after);
        int           base = int'(addr[13:4]);
        int           idx, beats = 0;
        bit           first = 1, have_hold = 0;
        logic [127:0] hold_d;
        logic         hold_l;
        rexp_t        e;
        for (int b = 0; b <= len; b++) begin
            idx = (burst == FIXED) ? base : (base + b) % 1024;
            exp_r.push_back('{data: burst[1] ? 128'd0 : model[idx], resp: burst[1] ? 2'b10 : 2'b00,
                              last: (b == len)});
        end
        ar_send(id, addr, len, burst);
        for (int cyc = 0; cyc < 600 && beats < stop_after; cyc++) begin
            ram_axi.rready = stall ? ((cyc % 2) == 0) : 1'b1;
            @(negedge aclk);
            if (first) begin
                check("r_latency", 128'(ram_axi.rvalid), 128'(1));
                first = 0;
            end
            if (ram_axi.rvalid) begin
                if (have_hold) begin
                    check("r_hold_data", ram_axi.rdata, hold_d);
                    check("r_hold_last", 128'(ram_axi.rlast), 128'(hold_l));
                    have_hold = 0;
                end
                if (ram_axi.rready) begin
                    e = exp_r.pop_front();
                    check("r_data", ram_axi.rdata, e.data);
                    check("r_resp", 128'(ram_axi.rresp), 128'(e.resp));
                    check("r_last", 128'(ram_axi.rlast), 128'(e.last));
                    check("r_id", 128'(ram_axi.rid), 128'(id));
                    beats++;
                end else begin
                    hold_d = ram_axi.rdata; hold_l = ram_axi.rlast; have_hold = 1;
                end
            end
            @(posedge aclk); #1;
        end
        ram_axi.rready = 1'b0;
        check("r_beats", 128'(beats), 128'(stop_after));
    endtask

    initial begin
        ram_axi.awid = '0; ram_axi.awaddr = '0; ram_axi.awlen = '0; ram_axi.awsize = 3'd4;
        ram_axi.awburst = INCR; ram_axi.awlock = 1'b0; ram_axi.awcache = '0; ram_axi.awprot = '0;
        ram_axi.awvalid = 1'b0; ram_axi.wdata = '0; ram_axi.wstrb = '0; ram_axi.wlast = 1'b0;
        ram_axi.wvalid = 1'b0; ram_axi.bready = 1'b0;
        ram_axi.arid = '0; ram_axi.araddr = '0; ram_axi.arlen = '0; ram_axi.arsize = 3'd4;
        ram_axi.arburst = INCR; ram_axi.arlock = 1'b0; ram_axi.arcache = '0; ram_axi.arprot = '0;
        ram_axi.arvalid = 1'b0; ram_axi.rready = 1'b0;

        repeat (3) @(posedge aclk);
        #1;
        check("rst_awready", 128'(ram_axi.awready), 128'(0));
        check("rst_arready", 128'(ram_axi.arready), 128'(0));
        check("rst_wready", 128'(ram_axi.wready), 128'(0));
        check("rst_bvalid", 128'(ram_axi.bvalid), 128'(0));
        check("rst_rvalid", 128'(ram_axi.rvalid), 128'(0));
        @(negedge aclk);
        areset = 1'b0;
        #1;
        check("awready_before_edge", 128'(ram_axi.awready), 128'(0));
        @(posedge aclk); #1;
        check("awready_after_edge", 128'(ram_axi.awready), 128'(1));
        check("arready_after_edge", 128'(ram_axi.arready), 128'(1));

        // Known contents for words 0..15 so later reads never see uninitialised array words.
        for (int i = 0; i < 16; i++) wbuf[i] = {4{32'h1000_0000 + 32'(i)}};
        write_burst(8'h01, 16'h0000, 15, INCR, 16'hFFFF, 15);

        wbuf[0] = {16{8'hA5}};
        write_burst(8'h11, 16'h0040, 0, INCR, 16'hFFFF, 0);
        read_burst(8'h22, 16'h0040, 0, INCR, 0, 1);

        wbuf[0] = '1;
        write_burst(8'h12, 16'h0030, 0, INCR, 16'hFFFF, 0);
        wbuf[0] = '0;
        write_burst(8'h13, 16'h0030, 0, INCR, 16'h000F, 0);
        check("strobe_model", model[3], {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'h0});
        read_burst(8'h23, 16'h0030, 0, INCR, 0, 1);

        for (int i = 0; i < 8; i++) wbuf[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        write_burst(8'h33, 16'h3FC0, 7, INCR, 16'hFFFF, 7);
        read_burst(8'h44, 16'h3FC0, 7, INCR, 1, 8);

        for (int i = 0; i < 4; i++) wbuf[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        write_burst(8'h55, 16'h0050, 3, FIXED, 16'hFFFF, 3);
        read_burst(8'h56, 16'h0050, 3, INCR, 0, 4);
        read_burst(8'h57, 16'h0050, 2, FIXED, 1, 3);

        wbuf[0] = '0; wbuf[1] = '0;
        write_burst(8'h66, 16'h0090, 1, WRAP, 16'hFFFF, 1);
        read_burst(8'h67, 16'h0090, 0, INCR, 0, 1);
        read_burst(8'h68, 16'h0090, 1, WRAP, 0, 2);

        for (int i = 0; i < 4; i++) wbuf[i] = {4{32'hC0DE_0000 + 32'(i)}};
        write_burst(8'h77, 16'h00A0, 3, INCR, 16'hFFFF, 1);
        read_burst(8'h79, 16'h00A0, 3, INCR, 0, 4);
        write_burst(8'h78, 16'h00E0, 1, INCR, 16'hFFFF, 99);

        read_burst(8'h88, 16'h0000, 7, INCR, 0, 2);
        @(negedge aclk);
        check("beat3_presented", 128'(ram_axi.rvalid), 128'(1));
        #2 areset = 1'b1;
        #1;
        check("abort_rvalid", 128'(ram_axi.rvalid), 128'(0));
        check("abort_rlast", 128'(ram_axi.rlast), 128'(0));
        exp_r.delete();
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        @(posedge aclk); #1;
        check("arready_after_abort", 128'(ram_axi.arready), 128'(1));
        read_burst(8'h99, 16'h0030, 0, INCR, 0, 1);
        read_burst(8'h9A, 16'h3FF0, 1, INCR, 0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/axi4_ram_responder.md
Name: axi4_ram_responder

Overview:
- AXI4 slave that answers the external-RAM AXI4 master port of the tree core.
- Stores binary-tree nodes in an internal word array.
- Used as the RAM endpoint in simulation and on small FPGA builds.
- Independent read and write engines; one outstanding transaction per direction; INCR and FIXED bursts up to 256 beats.

Parameters:
- RAM_DATA_WIDTH, 128, data bus width in bits; power of two, ≥ 32.
- RAM_ADDR_WIDTH, 16, byte-address width.
- RAM_STRB_WIDTH, RAM_DATA_WIDTH/8, write-strobe width.
- RAM_ID_WIDTH, 8, AXI ID width.
- RAM_DEPTH_W, 10, log2 of array depth in words (1024 words by default).

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous active-high reset
- ram_axi_awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot  in  RAM_ID_WIDTH/RAM_ADDR_WIDTH/8/3/2/1/4/3  write address
- ram_axi_awvalid  in  1 ; ram_axi_awready  out  1
- ram_axi_wdata  in  RAM_DATA_WIDTH ; ram_axi_wstrb  in  RAM_STRB_WIDTH ; ram_axi_wlast  in  1 ; ram_axi_wvalid  in  1 ; ram_axi_wready  out  1
- ram_axi_bid  out  RAM_ID_WIDTH ; ram_axi_bresp  out  2 ; ram_axi_bvalid  out  1 ; ram_axi_bready  in  1
- ram_axi_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot  in  same widths as AW  read address
- ram_axi_arvalid  in  1 ; ram_axi_arready  out  1
- ram_axi_rid  out  RAM_ID_WIDTH ; ram_axi_rdata  out  RAM_DATA_WIDTH ; ram_axi_rresp  out  2 ; ram_axi_rlast  out  1 ; ram_axi_rvalid  out  1 ; ram_axi_rready  in  1

Behaviour:
- Reset (areset=1, asynchronous): all outputs 0; both FSMs in IDLE. Array contents are not reset.
- awready/arready rise on the first aclk edge after reset release.
- Reset asserted mid-burst aborts the burst immediately; no further writes occur.
- Word index = addr[RAM_DEPTH_W+log2(RAM_STRB_WIDTH)-1 : log2(RAM_STRB_WIDTH)].
  - Upper address bits are ignored, so accesses alias modulo the array depth.
  - Low byte-offset bits are ignored.
  - awsize/arsize are ignored; every beat is full width. awlock, awcache, awprot (and AR equivalents) are ignored.
- Write FSM states: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: awready=1. On awvalid&awready, latch id, word index, beat count = awlen+1, and burst type; go to W_DATA.
  - W_DATA: wready=1. On each wvalid&wready, write bytes whose wstrb bit is set (strobe 0 leaves the byte unchanged). INCR: index+1 per beat, wrapping at the array end. FIXED: index constant.
  - On the beat where count reaches its final value, go to W_RESP.
  - wlast mismatch (asserted early, or deasserted on the final beat): burst still ends on beat count; bresp=SLVERR (2'b10).
  - W_RESP: bvalid=1, bid = latched awid, bresp = OKAY (2'b00) unless an error was flagged. Hold until bready, then W_IDLE.
- Read FSM states: R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: arready=1. On arvalid&arready, latch id, index, count, burst type; go to R_DATA.
  - R_DATA: rvalid is asserted the cycle after the AR handshake (latency 1), with rdata = array[index].
  - rid, rdata, rresp, rlast are held stable while rvalid=1 and rready=0.
  - On rvalid&rready: advance index (INCR) and present the next beat the following cycle with no bubble.
  - rlast=1 only on beat awlen/arlen+1 of the burst. After the last handshake, return to R_IDLE (arready reasserts the next cycle).
- arburst or awburst = WRAP (2'b10) or reserved (2'b11):
  - Write: accept all beats, write nothing, respond SLVERR.
  - Read: return every beat with rdata=0 and rresp=SLVERR.
- Simultaneous read and write to the same word in the same cycle: the read returns the pre-write data; the write commits at that edge.
- Read and write channels never block each other. AW and AR may handshake in the same cycle.

Test Plan:
- Single write then read: AW addr 0x0040, awlen=0, wdata=0xA5..A5, wstrb all ones → bresp=OKAY, bid=awid. AR 0x0040 → rdata=0xA5..A5, rlast=1, rvalid one cycle after the AR handshake.
- Strobe merge: write 0xFFFF..FF to word 3, then write 0x0 with wstrb=0x000F → read of word 3 returns 0xFFFF..FF_0000_0000 (low 4 bytes zero).
- INCR burst with backpressure: awlen=7 at word 1020 (wraps to word 0). Read back with rready toggling 1/0 → 8 beats in order, data stable during stalls, rlast only on beat 8.
- FIXED burst: 4 beats to word 5 → word 5 holds the beat-4 data; words 6–8 unchanged.
- Error cases: awburst=WRAP → bresp=SLVERR, memory unchanged. wlast on beat 2 of an awlen=3 burst → 4 beats accepted, bresp=SLVERR.
- Reset mid-read-burst: assert areset on beat 3 of 8 → rvalid=0 immediately. After release, arready=1 and a fresh read returns correct data.
